// File: rtl/mul_booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier:
//   - FSM state encoding
//   - Booth digit select encoding, packed as {negate, double, zero}
//   - booth_decode(): maps a 3-bit multiplier window to a digit select
package mul_booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Bit order is {negate, double, zero} so the flags can be unpacked directly.
   typedef enum logic [2:0] {
      SEL_P1   = 3'b000,
      SEL_ZERO = 3'b001,
      SEL_P2   = 3'b010,
      SEL_M1   = 3'b100,
      SEL_M2   = 3'b110
   } booth_sel_e;

   // Window is {b[i+1], b[i], b[i-1]}; digit = -2*b[i+1] + b[i] + b[i-1].
   function automatic booth_sel_e booth_decode(input logic [2:0] win);
      booth_sel_e sel;
      sel = SEL_ZERO;
      case (win)
         3'b000:  sel = SEL_ZERO;
         3'b001:  sel = SEL_P1;
         3'b010:  sel = SEL_P1;
         3'b011:  sel = SEL_P2;
         3'b100:  sel = SEL_M2;
         3'b101:  sel = SEL_M1;
         3'b110:  sel = SEL_M1;
         3'b111:  sel = SEL_ZERO;
         default: sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Combinational radix-4 Booth window decoder.
// Ports:
//   i_window  [2:0]  multiplier window {b[i+1], b[i], b[i-1]}
//   o_neg_c          subtract the selected multiple
//   o_dbl_c          use 2x multiplicand instead of 1x
//   o_zero_c         digit is zero (adds nothing)
module booth_r4_enc
   import mul_booth_pkg::*;
(
   input  logic [2:0] i_window,
   output logic       o_neg_c,
   output logic       o_dbl_c,
   output logic       o_zero_c
);

   booth_sel_e w_sel;

   // Decode window and unpack the select into individual flags.
   always_comb begin
      w_sel = booth_decode(i_window);
      {o_neg_c, o_dbl_c, o_zero_c} = 3'(w_sel);
   end

endmodule

// File: rtl/mul_booth_r4.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a multiplication (sampled only in IDLE)
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   in1, in2   multiplicand / multiplier (sampled with start)
//   out        product, held until the next completion
//   out_r      one-cycle result-ready pulse
//   busy       high whenever the FSM is not in IDLE
module mul_booth_r4
   import mul_booth_pkg::*;
#(
   parameter int unsigned BIT_LEN = 8
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   is_signed,
   input  logic [BIT_LEN-1:0]     in1,
   input  logic [BIT_LEN-1:0]     in2,
   output logic [2*BIT_LEN-1:0]   out,
   output logic                   out_r,
   output logic                   busy
);

   localparam int unsigned EXT_W  = BIT_LEN + 2;   // extended operand width
   localparam int unsigned ACC_W  = BIT_LEN + 4;   // headroom for +/-2*multiplicand
   localparam int unsigned N_ITER = EXT_W / 2;
   localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

   // ---------------- controller ----------------
   state_e           r_state;
   state_e           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_load;
   logic             w_iter;
   logic             w_finish;

   // Next-state and datapath control strobes.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_iter       = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN: begin
            // The extra RUN cycle after the last iteration transfers the product.
            if (r_cnt == CNT_W'(N_ITER)) begin
               w_finish     = 1'b1;
               w_next_state = DONE;
            end else begin
               w_iter = 1'b1;
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State, iteration counter and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         busy    <= 1'b0;
         out_r   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         busy    <= (w_next_state != IDLE);
         out_r   <= (w_next_state == DONE);
         if (w_load)
            r_cnt <= '0;
         else if (w_iter)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // ---------------- datapath ----------------
   logic [ACC_W-1:0] r_acc;
   logic [EXT_W-1:0] r_mcand;
   logic [EXT_W-1:0] r_mplr;
   logic             r_prev;

   logic [EXT_W-1:0] w_in1_ext;
   logic [EXT_W-1:0] w_in2_ext;
   logic [ACC_W-1:0] w_mcand_acc;
   logic [ACC_W-1:0] w_mult;
   logic [ACC_W-1:0] w_addend;
   logic [ACC_W-1:0] w_sum;
   logic             w_neg;
   logic             w_dbl;
   logic             w_zero;

   booth_r4_enc u_enc (
      .i_window ({r_mplr[1:0], r_prev}),
      .o_neg_c  (w_neg),
      .o_dbl_c  (w_dbl),
      .o_zero_c (w_zero)
   );

   // Operand extension, multiple selection and partial-product add.
   always_comb begin
      w_in1_ext   = is_signed ? {{2{in1[BIT_LEN-1]}}, in1} : {2'b00, in1};
      w_in2_ext   = is_signed ? {{2{in2[BIT_LEN-1]}}, in2} : {2'b00, in2};
      w_mcand_acc = {{2{r_mcand[EXT_W-1]}}, r_mcand};
      w_mult      = '0;
      if (!w_zero)
         w_mult = w_dbl ? {w_mcand_acc[ACC_W-2:0], 1'b0} : w_mcand_acc;
      w_addend    = w_neg ? (~w_mult + ACC_W'(1)) : w_mult;
      w_sum       = r_acc + w_addend;
   end

   // Accumulator / multiplier shift register and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc   <= '0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_prev  <= 1'b0;
         out     <= '0;
      end else if (w_load) begin
         r_acc   <= '0;
         r_mcand <= w_in1_ext;
         r_mplr  <= w_in2_ext;
         r_prev  <= 1'b0;
      end else if (w_iter) begin
         // Arithmetic shift right by 2 of {acc, mplr, prev} after the add.
         r_acc   <= {{2{w_sum[ACC_W-1]}}, w_sum[ACC_W-1:2]};
         r_mplr  <= {w_sum[1:0], r_mplr[EXT_W-1:2]};
         r_prev  <= r_mplr[1];
      end else if (w_finish) begin
         // All multiplier bits have shifted out; product sits in {acc, mplr}.
         out <= {r_acc[BIT_LEN-3:0], r_mplr};
      end
   end

endmodule

// File: tb/tb_mul_booth_r4.sv
// Self-checking bench for mul_booth_r4 (BIT_LEN = 8): directed corners plus
// randomized single and back-to-back operations against an arithmetic model.
module tb_mul_booth_r4;

   localparam int unsigned BL  = 8;
   localparam int unsigned LAT = 6;   // edges from accept edge to out_r

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            is_signed;
   logic [BL-1:0]   in1;
   logic [BL-1:0]   in2;
   logic [2*BL-1:0] out;
   logic            out_r;
   logic            busy;

   int n_chk = 0;
   int n_err = 0;

   mul_booth_r4 #(.BIT_LEN(BL)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .in1       (in1),
      .in2       (in2),
      .out       (out),
      .out_r     (out_r),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer multiply, truncated to 2*BL bits.
   function automatic logic [2*BL-1:0] ref_mul(input logic sgn, input logic [BL-1:0] a,
                                               input logic [BL-1:0] b);
      longint p;
      if (sgn) p = longint'($signed(a)) * longint'($signed(b));
      else     p = longint'(a) * longint'(b);
      return p[2*BL-1:0];
   endfunction

   // One operation started from IDLE; inputs scrambled after acceptance.
   // poke_at > 0 raises start with junk operands for one cycle during RUN.
   task automatic run_op(input string tag, input logic sgn, input logic [BL-1:0] a,
                         input logic [BL-1:0] b, input int poke_at);
      logic [2*BL-1:0] exp;
      int cyc;
      bit seen;
      exp = ref_mul(sgn, a, b);
      @(negedge clk);
      is_signed = sgn; in1 = a; in2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in1 = BL'($urandom); in2 = BL'($urandom); is_signed = 1'($urandom);
      chk({tag, ":busy_e0"}, 32'(busy), 32'd1);
      cyc = 0; seen = 0;
      while (!seen && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == poke_at) ? 1'b1 : 1'b0;
         if (cyc == poke_at) begin
            in1 = BL'($urandom); in2 = BL'($urandom);
         end
         if (out_r) seen = 1;
      end
      start = 1'b0;
      chk({tag, ":latency"}, 32'(cyc), 32'(LAT));
      chk({tag, ":out"}, 32'(out), 32'(exp));
      @(posedge clk); #1;
      chk({tag, ":out_r_low"}, 32'(out_r), 32'd0);
      chk({tag, ":busy_low"}, 32'(busy), 32'd0);
      chk({tag, ":out_hold"}, 32'(out), 32'(exp));
   endtask

   // Count out_r pulses over a fixed window of idle cycles.
   task automatic quiet(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (out_r) pulses++;
      end
      chk({tag, ":no_pulse"}, 32'(pulses), 32'd0);
      chk({tag, ":idle"}, 32'(busy), 32'd0);
   endtask

   // start held high continuously; each new operand set is presented in DONE.
   task automatic back_to_back(input int n);
      logic [2*BL-1:0] exp;
      int cyc;
      bit seen;
      @(negedge clk);
      is_signed = 1'($urandom); in1 = BL'($urandom); in2 = BL'($urandom);
      start = 1'b1;
      for (int i = 0; i < n; i++) begin
         exp = ref_mul(is_signed, in1, in2);
         cyc = 0; seen = 0;
         while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (out_r) seen = 1;
         end
         chk("b2b:latency", 32'(cyc), (i == 0) ? 32'(LAT + 1) : 32'(LAT + 2));
         chk("b2b:out", 32'(out), 32'(exp));
         if (i == n - 1) start = 1'b0;
         is_signed = 1'($urandom); in1 = BL'($urandom); in2 = BL'($urandom);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("b2b:idle", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; in1 = '0; in2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset:out", 32'(out), 32'd0);
      chk("reset:out_r", 32'(out_r), 32'd0);
      chk("reset:busy", 32'(busy), 32'd0);
      @(negedge clk); rst = 1'b0;

      // Directed corners.
      run_op("s_min_sq", 1'b1, 8'h80, 8'h80, 0);
      chk("s_min_sq:value", 32'(out), 32'h4000);
      run_op("u_max_sq", 1'b0, 8'hFF, 8'hFF, 0);
      chk("u_max_sq:value", 32'(out), 32'hFE01);
      run_op("s_ff_01", 1'b1, 8'hFF, 8'h01, 0);
      chk("s_ff_01:value", 32'(out), 32'hFFFF);
      run_op("u_ff_01", 1'b0, 8'hFF, 8'h01, 0);
      chk("u_ff_01:value", 32'(out), 32'h00FF);
      run_op("zero_a", 1'b1, 8'h00, 8'h5A, 0);
      run_op("zero_b", 1'b0, 8'hC3, 8'h00, 0);
      run_op("s_max_min", 1'b1, 8'h7F, 8'h80, 0);

      // start pulsed during RUN must be dropped, not queued.
      run_op("busy_start", 1'b0, 8'h03, 8'h05, 2);
      chk("busy_start:value", 32'(out), 32'h000F);
      quiet("busy_start", 10);

      // Reset during RUN aborts without a pulse.
      @(negedge clk);
      is_signed = 1'b0; in1 = 8'h7F; in2 = 8'h7F; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort:out", 32'(out), 32'd0);
      chk("abort:busy", 32'(busy), 32'd0);
      chk("abort:out_r", 32'(out_r), 32'd0);
      @(negedge clk); rst = 1'b0;
      quiet("abort", 10);
      run_op("after_abort", 1'b0, 8'd3, 8'd7, 0);
      chk("after_abort:value", 32'(out), 32'h0015);

      // Randomized regression.
      for (int i = 0; i < 5000; i++)
         run_op("rand", 1'($urandom), BL'($urandom), BL'($urandom), 0);
      back_to_back(5000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mul_booth_r4.md
MUL_BOOTH_R4 -- requirements
Module: mul_booth_r4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: BIT_LEN, default 8, operand width in bits; legal values are even and >= 4.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-006 Port: is_signed  input  1  1 = two's-complement operands, 0 = unsigned operands; sampled with start.
REQ-007 Port: in1  input  BIT_LEN  multiplicand; sampled with start.
REQ-008 Port: in2  input  BIT_LEN  multiplier; sampled with start.
REQ-009 Port: out  output  2*BIT_LEN  product; holds its value until the next completion.
REQ-010 Port: out_r  output  1  result-ready pulse, exactly one cycle wide.
REQ-011 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 Transition IDLE->RUN SHALL occur on the edge where start=1 (edge E0).
REQ-014 On edge E0 the block SHALL capture in1, in2 and is_signed into internal registers.
REQ-015 On capture, each operand SHALL be extended to BIT_LEN+2 bits: sign-extended if is_signed=1, zero-extended if is_signed=0.
REQ-016 RUN SHALL last N = (BIT_LEN+2)/2 cycles, counted by an iteration counter.
REQ-017 Each RUN cycle SHALL decode one radix-4 Booth digit in {-2,-1,0,+1,+2} from the 3-bit multiplier window (implicit 0 below the LSB).
REQ-018 Each RUN cycle SHALL add the selected multiple of the multiplicand to the partial product and arithmetic-shift the product/multiplier register right by 2.
REQ-019 The accumulator SHALL be BIT_LEN+4 bits wide, so that +/-2*multiplicand never overflows.
REQ-020 After the last RUN iteration, RUN->DONE; on that same edge (E0+N+1), out SHALL load the low 2*BIT_LEN bits of the exact product.
REQ-021 In DONE, out_r SHALL be 1; DONE->IDLE SHALL occur unconditionally on the next edge, where out_r returns to 0.
REQ-022 busy SHALL be 1 from edge E0 until the DONE->IDLE edge.
REQ-023 busy SHALL be 0 in IDLE; the next start is accepted no earlier than the first edge at which the FSM is in IDLE.
REQ-024 start asserted in RUN or DONE SHALL be ignored (not queued).
REQ-025 in1, in2 and is_signed changing after E0 SHALL NOT affect the result in progress.
REQ-026 Boundary: the signed product -2^(BIT_LEN-1) * -2^(BIT_LEN-1) SHALL be exact (+2^(2*BIT_LEN-2)).
REQ-027 Boundary: the unsigned product (2^BIT_LEN-1)^2 SHALL be exact.
REQ-028 Boundary: a zero operand SHALL still take the full N cycles (fixed latency).

Reset
REQ-029 While rst=1: FSM = IDLE, out = 0, out_r = 0, busy = 0, and the counter and all datapath registers = 0.
REQ-030 A reset asserted during RUN or DONE SHALL abort the operation with no out_r pulse; the next start after release SHALL behave as from power-up.

Structure
REQ-031 Package mul_booth_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the Booth digit select encoding.
REQ-032 The block SHALL be split into a controller FSM plus a datapath.
REQ-033 The combinational Booth window decoder SHALL be one sub-module, booth_r4_enc (3-bit window in; negate, double and zero flags out).

Verification (BIT_LEN=8, N=5)
REQ-034 Signed corner: is_signed=1, in1=in2=8'h80, start at E0 -> out=16'h4000 with out_r=1 exactly at E0+6; busy high from E0 until E0+7.
REQ-035 Unsigned corner: is_signed=0, in1=in2=8'hFF -> out=16'hFE01.
REQ-036 Mode difference: is_signed=1, in1=8'hFF, in2=8'h01 -> out=16'hFFFF; the same operands with is_signed=0 -> out=16'h00FF.
REQ-037 Start while busy: start pulsed at E0+2 with other operands -> ignored; out holds the first result with a single out_r pulse.
REQ-038 Reset abort: rst asserted at E0+3 -> out=0, busy=0, no out_r; a new start 3*7=21 then returns 16'h0015 at the expected latency.
REQ-039 Random regression: 10k random operand/mode pairs checked against a reference multiply, including back-to-back starts held high continuously.
